// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-address sprite ROM port among NUM_REQ fetch units,
// with an optional per-requester burst lock and ID-tagged responses two cycles after acceptance.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    logic [ID_W-1:0]   r_ptr;
    logic              r_lock_v;
    logic [ID_W-1:0]   r_lock_id;
    logic              r_tag1_v;
    logic [ID_W-1:0]   r_tag1_id;
    logic              r_tag2_v;
    logic [ID_W-1:0]   r_tag2_id;
    logic [ADDR_W-1:0] r_rom_address;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [DATA_W-1:0] r_rsp_data;

    logic              w_grant_v;
    logic [ID_W-1:0]   w_grant_id;
    logic [ID_W-1:0]   w_ptr_next;
    logic [ADDR_W-1:0] w_grant_addr;

    // Explicit compare-and-subtract wrap keeps non-power-of-2 NUM_REQ correct.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum > NUM_REQ - 1) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_grant_v  = 1'b0;
        w_grant_id = '0;
        if (r_lock_v && req_valid[r_lock_id]) begin
            w_grant_v  = 1'b1;
            w_grant_id = r_lock_id;
        end else begin
            // Scan from the far end so the candidate closest to r_ptr is written last and wins.
            for (int off = NUM_REQ - 1; off >= 0; off--) begin
                if (req_valid[wrap_idx(r_ptr, off)]) begin
                    w_grant_v  = 1'b1;
                    w_grant_id = wrap_idx(r_ptr, off);
                end
            end
        end
        if (reset) begin
            w_grant_v = 1'b0;
        end
    end

    assign w_ptr_next   = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
    assign w_grant_addr = req_addr[int'(w_grant_id)*ADDR_W +: ADDR_W];
    assign req_ready    = w_grant_v ? (NUM_REQ'(1) << w_grant_id) : '0;

    // Arbitration state: pointer, lock owner and the registered ROM address.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_ptr         <= '0;
            r_lock_v      <= 1'b0;
            r_lock_id     <= '0;
            r_rom_address <= '0;
        end else if (w_grant_v) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_ptr         <= w_ptr_next;
            r_lock_v      <= req_lock[w_grant_id];
            r_lock_id     <= w_grant_id;
            r_rom_address <= w_grant_addr;
        end else begin
            r_lock_v      <= 1'b0;
        end
    end

    // Tag pipeline tracks the ROM's one-cycle address register; an idle cycle inserts v=0.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_tag1_v    <= 1'b0;
            r_tag1_id   <= '0;
            r_tag2_v    <= 1'b0;
            r_tag2_id   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_tag1_v    <= w_grant_v;
            r_tag1_id   <= w_grant_id;
            r_tag2_v    <= r_tag1_v;
            r_tag2_id   <= r_tag1_id;
            r_rsp_valid <= r_tag2_v;
            if (r_tag2_v) begin
                r_rsp_id   <= r_tag2_id;
                r_rsp_data <= rom_q;
            end
        end
    end

    assign rom_address = r_rom_address;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_data    = r_rsp_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model and a behavioural registered-address ROM.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 2;
    localparam int ID_W    = 2;

    logic                      vga_clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_q;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
    );

    always #5 vga_clk = ~vga_clk;

    // Behavioural sprite ROM: address registered on the clock edge, data out one cycle later.
    logic [DATA_W-1:0] rom_mem [1<<ADDR_W];
    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    typedef struct {
        int                due;
        int                id;
        logic [ADDR_W-1:0] addr;
    } exp_rsp_t;

    exp_rsp_t          m_q[$];
    int                m_ptr;
    int                m_lock;
    int                cyc;
    int                last_grant;
    logic              exp_rsp_v;
    logic [ID_W-1:0]   exp_rsp_id;
    logic [DATA_W-1:0] exp_rsp_data;
    logic [ADDR_W-1:0] exp_rom_addr;
    int                checks;
    int                failures;

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return req_addr[i*ADDR_W +: ADDR_W];
    endfunction

    function automatic int model_grant();
        if (reset) return -1;
        if (m_lock >= 0 && req_valid[m_lock]) return m_lock;
        for (int off = 0; off < NUM_REQ; off++) begin
            int i = (m_ptr + off) % NUM_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int g);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Advance one clock and update the reference model from the inputs seen at that edge.
    task automatic tick();
        int                g;
        logic [ADDR_W-1:0] ga;
        logic              gl;
        exp_rsp_t          e;
        g  = model_grant();
        ga = (g >= 0) ? addr_of(g) : '0;
        gl = (g >= 0) ? req_lock[g] : 1'b0;
        last_grant = g;
        @(posedge vga_clk);
        cyc++;
        if (reset) begin
            m_q.delete();
            m_ptr        = 0;
            m_lock       = -1;
            exp_rom_addr = '0;
            exp_rsp_v    = 1'b0;
            exp_rsp_id   = '0;
            exp_rsp_data = '0;
        end else begin
            exp_rsp_v = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                e            = m_q.pop_front();
                exp_rsp_v    = 1'b1;
                exp_rsp_id   = ID_W'(e.id);
                exp_rsp_data = rom_mem[e.addr];
            end
            if (g >= 0) begin
                exp_rom_addr = ga;
                m_ptr        = (g + 1) % NUM_REQ;
                m_lock       = gl ? g : -1;
                m_q.push_back('{due: cyc + 2, id: g, addr: ga});
            end else begin
                m_lock = -1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        req_addr  = {$urandom, $urandom};
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rom_address !== '0 || rsp_id !== '0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_values: got v=%b addr=%0d id=%0d data=%0d expected all 0",
                     rsp_valid, rom_address, rsp_id, rsp_data);
        end
        reset     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL idle_ready: cycle %0d got %b expected 0000", i, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || rom_address !== '0) begin
                failures++;
                $display("FAIL idle_outputs: cycle %0d got v=%b addr=%0d expected v=0 addr=0",
                         i, rsp_valid, rom_address);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req_valid            = 4'b0001;
        req_lock             = '0;
        req_addr[0 +: ADDR_W] = 9'd37;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rom_address !== 9'd37) begin
            failures++;
            $display("FAIL single_rom_address: got %0d expected 37", rom_address);
        end
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++;
            if (rsp_valid !== (j == 2)) begin
                failures++;
                $display("FAIL single_rsp_valid: edge +%0d got %b expected %b", j, rsp_valid, j == 2);
            end
            if (j == 2) begin
                checks++;
                if (rsp_id !== 2'd0 || rsp_data !== rom_mem[37]) begin
                    failures++;
                    $display("FAIL single_rsp: got id=%0d data=%0d expected id=0 data=%0d",
                             rsp_id, rsp_data, rom_mem[37]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req_lock = '0;
        req_addr = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            req_valid = (i < 6) ? 4'b1111 : 4'b0000;
            #1;
            if (i < 6) begin
                checks++;
                if (req_ready !== onehot(seq[i])) begin
                    failures++;
                    $display("FAIL rr_grant: step %0d got %b expected %b", i, req_ready, onehot(seq[i]));
                end
            end
            tick();
            if (i < 6) req_addr[seq[i]*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            if (i >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(seq[i-2]) || rsp_data !== exp_rsp_data) begin
                    failures++;
                    $display("FAIL rr_rsp: step %0d got v=%b id=%0d data=%0d expected v=1 id=%0d data=%0d",
                             i, rsp_valid, rsp_id, rsp_data, seq[i-2], exp_rsp_data);
                end
            end
        end
    endtask

    task automatic test_lock();
        int seq [5] = '{1, 2, 2, 2, 1};
        do_reset();
        req_addr = {$urandom, $urandom};
        for (int i = 0; i < 7; i++) begin
            req_valid = (i < 5) ? 4'b0110 : 4'b0000;
            req_lock  = (i == 1 || i == 2) ? 4'b0100 : 4'b0000;
            #1;
            if (i < 5) begin
                checks++;
                if (req_ready !== onehot(seq[i])) begin
                    failures++;
                    $display("FAIL lock_grant: step %0d got %b expected %b", i, req_ready, onehot(seq[i]));
                end
            end
            tick();
            if (i >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(seq[i-2])) begin
                    failures++;
                    $display("FAIL lock_rsp: step %0d got v=%b id=%0d expected v=1 id=%0d",
                             i, rsp_valid, rsp_id, seq[i-2]);
                end
            end
        end
        req_lock = '0;
    endtask

    task automatic test_lock_drop();
        do_reset();
        req_addr  = {$urandom, $urandom};
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL lock_drop_first: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        req_lock  = 4'b0000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL lock_drop_same_cycle: got %b expected 1000", req_ready);
        end
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== exp_rsp_v || (exp_rsp_v && rsp_id !== exp_rsp_id)) begin
                failures++;
                $display("FAIL lock_drop_rsp: step %0d got v=%b id=%0d expected v=%b id=%0d",
                         i, rsp_valid, rsp_id, exp_rsp_v, exp_rsp_id);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_addr  = {$urandom, $urandom};
        req_lock  = '0;
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0010;
        #1;
        tick();
        reset     = 1'b1;
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL midreset_ready: got %b expected 0000", req_ready);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || rom_address !== '0) begin
                failures++;
                $display("FAIL midreset_quiet: step %0d got v=%b addr=%0d expected v=0 addr=0",
                         i, rsp_valid, rom_address);
            end
            tick();
        end
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_ptr: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== exp_rsp_v || (exp_rsp_v && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                failures++;
                $display("FAIL midreset_rsp: step %0d got v=%b id=%0d data=%0d expected v=%b id=%0d data=%0d",
                         i, rsp_valid, rsp_id, rsp_data, exp_rsp_v, exp_rsp_id, exp_rsp_data);
            end
        end
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] pending;
        logic [NUM_REQ-1:0] lock_req;
        do_reset();
        pending  = '0;
        lock_req = '0;
        for (int n = 0; n < 403; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (n < 400 && !pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i]                  = 1'b1;
                    lock_req[i]                 = 1'($urandom_range(0, 1));
                    req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                end
            end
            req_valid = pending;
            req_lock  = lock_req & pending;
            reset     = (n < 400) && ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if (req_ready !== onehot(model_grant())) begin
                failures++;
                $display("FAIL rand_ready: step %0d got %b expected %b", n, req_ready, onehot(model_grant()));
            end
            tick();
            reset = 1'b0;
            if (last_grant >= 0) pending[last_grant] = 1'b0;
            checks++;
            if (rom_address !== exp_rom_addr || rsp_valid !== exp_rsp_v ||
                (exp_rsp_v && (rsp_id !== exp_rsp_id || rsp_data !== exp_rsp_data))) begin
                failures++;
                $display("FAIL rand_outputs: step %0d got addr=%0d v=%b id=%0d data=%0d expected addr=%0d v=%b id=%0d data=%0d",
                         n, rom_address, rsp_valid, rsp_id, rsp_data,
                         exp_rom_addr, exp_rsp_v, exp_rsp_id, exp_rsp_data);
            end
        end
        req_valid = '0;
        req_lock  = '0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        m_ptr      = 0;
        m_lock     = -1;
        last_grant = -1;
        exp_rsp_v  = 1'b0;
        reset      = 1'b1;
        req_valid  = '0;
        req_lock   = '0;
        req_addr   = '0;

        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_lock_drop();
        test_reset_mid();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
